// File: rtl/t08_instr_pkg.sv
// Shared types and constants for the t08 instruction-side responder.
package t08_instr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RETRY = 2'd2
  } instr_state_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/t08_instr_timeout.sv
// Wait counter for an outstanding fetch: counts enabled cycles, flags the last allowed one.
// Purely registered count with a combinational terminal flag; no handshake of its own.
module t08_instr_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  assign tc = (count_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/t08_instr_responder.sv
// Instruction fetch responder: one-entry tagged buffer in front of a req/ack memory port.
// Hits add no latency; a miss costs one cycle to issue plus the ack delay, and freeze holds the PC meanwhile.
module t08_instr_responder
  import t08_instr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] program_counter,
  input  logic        fetch_en,
  input  logic        ext_freeze,
  input  logic        flush,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic [31:0] mem_address,
  output logic [31:0] instruction,
  output logic        instruction_valid,
  output logic        freeze,
  output logic        fetch_error
);

  instr_state_t state_q, state_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         drop_q, drop_d;
  logic         buf_valid_q, buf_valid_d;
  logic [31:0]  buf_tag_q, buf_tag_d;
  logic [31:0]  buf_data_q, buf_data_d;
  logic         fetch_error_q, fetch_error_d;

  logic         timer_clr;
  logic         timer_en;
  logic         timer_tc;
  logic [31:0]  pc_word;
  logic         hit;

  assign pc_word = program_counter & WORD_MASK;
  assign hit     = buf_valid_q && (buf_tag_q == pc_word);

  assign instruction_valid = fetch_en && hit;
  assign freeze            = ext_freeze || (fetch_en && !hit);
  assign instruction       = buf_data_q;
  assign mem_read          = (state_q == BUSY);
  assign mem_address       = (state_q == BUSY) ? req_addr_q : 32'h0;
  assign fetch_error       = fetch_error_q;

  t08_instr_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .en  (timer_en),
    .tc  (timer_tc)
  );

  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    drop_d        = drop_q;
    buf_valid_d   = buf_valid_q;
    buf_tag_d     = buf_tag_q;
    buf_data_d    = buf_data_q;
    fetch_error_d = fetch_error_q;
    timer_clr     = 1'b1;
    timer_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (fetch_en && !hit) begin
          req_addr_d = pc_word;
          drop_d     = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        timer_clr = 1'b0;
        if (flush) begin
          drop_d = 1'b1;
        end
        if (mem_ack) begin
          // A flush in the ack cycle must also discard the returning word.
          if (!drop_q && !flush) begin
            buf_tag_d   = req_addr_q;
            buf_data_d  = mem_rdata;
            buf_valid_d = 1'b1;
          end
          state_d = IDLE;
        end else if (timer_tc) begin
          fetch_error_d = 1'b1;
          state_d       = RETRY;
        end else begin
          timer_en = 1'b1;
        end
      end
      RETRY: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_addr_q    <= 32'h0;
      drop_q        <= 1'b0;
      buf_valid_q   <= 1'b0;
      buf_tag_q     <= 32'h0;
      buf_data_q    <= 32'h0;
      fetch_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      drop_q        <= drop_d;
      buf_valid_q   <= buf_valid_d;
      buf_tag_q     <= buf_tag_d;
      buf_data_q    <= buf_data_d;
      fetch_error_q <= fetch_error_d;
    end
  end

endmodule

// File: tb/tb_t08_instr_responder.sv
// Directed bench for t08_instr_responder with a short timeout so retry behaviour is reachable.
module tb_t08_instr_responder;

  logic        clk;
  logic        rst;
  logic [31:0] program_counter;
  logic        fetch_en;
  logic        ext_freeze;
  logic        flush;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic [31:0] mem_address;
  logic [31:0] instruction;
  logic        instruction_valid;
  logic        freeze;
  logic        fetch_error;

  int n_checks = 0;
  int n_errors = 0;

  t08_instr_responder #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .program_counter   (program_counter),
    .fetch_en          (fetch_en),
    .ext_freeze        (ext_freeze),
    .flush             (flush),
    .mem_ack           (mem_ack),
    .mem_rdata         (mem_rdata),
    .mem_read          (mem_read),
    .mem_address       (mem_address),
    .instruction       (instruction),
    .instruction_valid (instruction_valid),
    .freeze            (freeze),
    .fetch_error       (fetch_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, outputs are sampled #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; program_counter = 32'h0; fetch_en = 1'b0; ext_freeze = 1'b0;
    flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_ivalid", {31'b0, instruction_valid}, 32'd0);
    chk("rst_freeze", {31'b0, freeze}, 32'd0);
    chk("rst_fetch_error", {31'b0, fetch_error}, 32'd0);

    // First miss at PC 0, ack three cycles after mem_read rises.
    tick();
    fetch_en = 1'b1; program_counter = 32'h0;
    settle();
    chk("miss0_freeze", {31'b0, freeze}, 32'd1);
    chk("miss0_mem_read_n", {31'b0, mem_read}, 32'd0);
    tick();
    chk("miss0_mem_read_n1", {31'b0, mem_read}, 32'd1);
    chk("miss0_addr", mem_address, 32'h0);
    tick();
    chk("miss0_freeze_b1", {31'b0, freeze}, 32'd1);
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    settle();
    chk("miss0_freeze_ack", {31'b0, freeze}, 32'd1);
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    settle();
    chk("fill0_instr", instruction, 32'h0000_0013);
    chk("fill0_ivalid", {31'b0, instruction_valid}, 32'd1);
    chk("fill0_freeze", {31'b0, freeze}, 32'd0);
    chk("fill0_mem_read", {31'b0, mem_read}, 32'd0);

    // Held PC keeps hitting without touching memory.
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("hold%0d_mem_read", i), {31'b0, mem_read}, 32'd0);
      chk($sformatf("hold%0d_ivalid", i), {31'b0, instruction_valid}, 32'd1);
    end
    ext_freeze = 1'b1;
    settle();
    chk("extfrz_freeze", {31'b0, freeze}, 32'd1);
    chk("extfrz_ivalid", {31'b0, instruction_valid}, 32'd1);
    ext_freeze = 1'b0;

    // PC 4: best-case ack in the first request cycle.
    tick();
    program_counter = 32'h4;
    settle();
    chk("pc4_ivalid", {31'b0, instruction_valid}, 32'd0);
    tick();
    chk("pc4_mem_read", {31'b0, mem_read}, 32'd1);
    chk("pc4_addr", mem_address, 32'h4);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 1'b0;
    settle();
    chk("pc4_instr", instruction, 32'h1111_1111);
    chk("pc4_ivalid_fill", {31'b0, instruction_valid}, 32'd1);

    // Unaligned PC: word address used, low bits ignored by the tag compare.
    tick();
    program_counter = 32'h102;
    tick();
    chk("pc102_addr", mem_address, 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0100;
    tick();
    mem_ack = 1'b0;
    settle();
    chk("pc102_ivalid", {31'b0, instruction_valid}, 32'd1);
    program_counter = 32'h100;
    settle();
    chk("pc100_hit", {31'b0, instruction_valid}, 32'd1);
    tick();
    chk("pc100_no_read", {31'b0, mem_read}, 32'd0);
    program_counter = 32'h103;
    settle();
    chk("pc103_hit", {31'b0, instruction_valid}, 32'd1);
    fetch_en = 1'b0;
    settle();
    chk("fen0_ivalid", {31'b0, instruction_valid}, 32'd0);
    chk("fen0_freeze", {31'b0, freeze}, 32'd0);
    fetch_en = 1'b1;

    // Flush coinciding with ack: data discarded, refetch follows.
    tick();
    program_counter = 32'h200;
    tick();
    chk("fl_mem_read", {31'b0, mem_read}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; flush = 1'b1;
    tick();
    mem_ack = 1'b0; flush = 1'b0;
    settle();
    chk("fl_ivalid", {31'b0, instruction_valid}, 32'd0);
    chk("fl_instr_kept", instruction, 32'hA5A5_0100);
    chk("fl_freeze", {31'b0, freeze}, 32'd1);
    tick();
    chk("fl_refetch", {31'b0, mem_read}, 32'd1);
    chk("fl_refetch_addr", mem_address, 32'h200);
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    tick();
    mem_ack = 1'b0;
    settle();
    chk("fl_fill", instruction, 32'h2222_2222);

    // Timeout: four request cycles, one retry cycle, then reissue.
    tick();
    program_counter = 32'h300;
    tick();
    chk("to_err_before", {31'b0, fetch_error}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_read%0d", i), {31'b0, mem_read}, 32'd1);
      tick();
    end
    chk("to_retry_read", {31'b0, mem_read}, 32'd0);
    chk("to_retry_addr", mem_address, 32'h0);
    chk("to_err_set", {31'b0, fetch_error}, 32'd1);
    tick();
    tick();
    chk("to_reissue", {31'b0, mem_read}, 32'd1);
    chk("to_reissue_addr", mem_address, 32'h300);
    mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
    tick();
    mem_ack = 1'b0;
    settle();
    chk("to_fill_ivalid", {31'b0, instruction_valid}, 32'd1);
    chk("to_err_sticky", {31'b0, fetch_error}, 32'd1);

    // Reset in the middle of a request; late ack must be ignored.
    tick();
    program_counter = 32'h400;
    tick();
    chk("mr_busy", {31'b0, mem_read}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h4444_4444;
    settle();
    chk("mr_read_low", {31'b0, mem_read}, 32'd0);
    chk("mr_err_clr", {31'b0, fetch_error}, 32'd0);
    chk("mr_instr", instruction, 32'h0);
    tick();
    mem_ack = 1'b0;
    settle();
    chk("mr_ack_ignored", instruction, 32'h0);
    chk("mr_fresh_req", {31'b0, mem_read}, 32'd1);
    chk("mr_fresh_addr", mem_address, 32'h400);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
